// File: rtl/line_memory_if.sv
// Request/response bundle between the data cache (master) and the line memory (slave).
interface line_memory_if;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] data_to_mem;
  logic         mem_ready;
  logic [127:0] data_from_mem;

  modport master (
    output mem_read, mem_write, mem_addr, data_to_mem,
    input  mem_ready, data_from_mem
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, data_to_mem,
    output mem_ready, data_from_mem
  );
endinterface

// File: rtl/line_memory.sv
// Fixed-latency 128-bit line memory answering cache line fills and write-backs.
// Optional MEM_STATS_EN adds rd_count/wr_count completion counters.
module line_memory #(
  parameter int LATENCY     = 20,
  parameter int DEPTH_LINES = 1024,
  parameter int IDX_W       = 10
) (
  input  logic          clk,
  input  logic          reset,
  line_memory_if.slave  bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t              state;
  logic [7:0]          count;
  logic                op_wr;
  logic [IDX_W-1:0]    idx;
  logic [127:0]        wdata;
  logic [127:0]        mem [DEPTH_LINES];
  logic                req;
  logic                finish;
  logic                addr_unused;

  assign req         = bus.mem_read | bus.mem_write;
  assign finish      = (state == BUSY) && (count == 8'd0);
  assign addr_unused = ^{bus.mem_addr[31:IDX_W+4], bus.mem_addr[3:0]};

  // Control FSM; mem_ready and data_from_mem are registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      count             <= 8'd0;
      bus.mem_ready     <= 1'b0;
      bus.data_from_mem <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            count <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (count != 8'd0) begin
            count <= count - 8'd1;
          end else begin
            if (!op_wr) bus.data_from_mem <= mem[idx];
            bus.mem_ready <= 1'b1;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture; a simultaneous read+write is treated as a write
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      op_wr <= bus.mem_write;
      idx   <= bus.mem_addr[IDX_W+3:4];
      wdata <= bus.data_to_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (finish && op_wr) mem[idx] <= wdata;
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (finish) begin
      if (op_wr) wr_count <= wr_count + 32'd1;
      else       rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: LATENCY=20 and LATENCY=1 instances against a line-level model.
module tb_line_memory;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_memory_if b20();
  line_memory_if b1();

`ifdef MEM_STATS_EN
  logic [31:0] rc20, wc20, rc1, wc1;
`endif

  line_memory #(.LATENCY(20), .DEPTH_LINES(1024), .IDX_W(10)) dut20 (
    .clk(clk), .reset(reset), .bus(b20)
`ifdef MEM_STATS_EN
    , .rd_count(rc20), .wr_count(wc20)
`endif
  );

  line_memory #(.LATENCY(1), .DEPTH_LINES(1024), .IDX_W(10)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
`ifdef MEM_STATS_EN
    , .rd_count(rc1), .wr_count(wc1)
`endif
  );

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LA   = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] LB   = 128'h5A5A5A5A_12345678_9ABCDEF0_5A5A5A5A;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] OLD  = 128'h00001111_22223333_44445555_66667777;
  localparam logic [127:0] NEW  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D1   = 128'hC0FFEE00_11223344_55667788_99AABBCC;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line-level model: contents by line number, plus the cycle each response is due
  logic [127:0] mdl [int];
  int           pulse20 = -1;
  int           accept20 = 0;
  int           last_pulse20 = -1;
  bit           pend_rd = 1'b0;
  logic [127:0] pend_data = '0;
  logic [127:0] exp_d20 = '0;
  int           p1_start = 1 << 30;
  bit           exp1;

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  always @(negedge clk) begin
    if (cyc == pulse20 && pend_rd) exp_d20 = pend_data;
    check("ready20", 128'(b20.mem_ready), 128'(cyc == pulse20));
    check("data20", b20.data_from_mem, exp_d20);
    if (b20.mem_ready) last_pulse20 = cyc;
    exp1 = (cyc >= p1_start) && (cyc <= p1_start + 15) && ((cyc - p1_start) % 3 == 0);
    check("ready1", 128'(b1.mem_ready), 128'(exp1));
    check("data1", b1.data_from_mem, (cyc >= p1_start + 6) ? D1 : 128'd0);
  end

  // Called just after a rising edge while dut20 is idle; returns in the cycle after mem_ready
  task automatic req20(input bit rd, input bit wr, input logic [31:0] addr, input logic [127:0] d);
    int k;
    b20.mem_read    = rd;
    b20.mem_write   = wr;
    b20.mem_addr    = addr;
    b20.data_to_mem = d;
    k        = cyc + 1;
    accept20 = k;
    pulse20  = k + 20;
    pend_rd  = rd && !wr;
    if (wr) mdl[line_of(addr)] = d;
    else    pend_data = mdl[line_of(addr)];
    @(posedge clk); #1;
    b20.mem_addr    = ~addr;
    b20.data_to_mem = ~d;
    repeat (21) @(posedge clk);
    #1;
    b20.mem_read  = 1'b0;
    b20.mem_write = 1'b0;
  endtask

  initial begin
    b20.mem_read = 1'b0; b20.mem_write = 1'b0; b20.mem_addr = '0; b20.data_to_mem = '0;
    b1.mem_read  = 1'b0; b1.mem_write  = 1'b0; b1.mem_addr  = '0; b1.data_to_mem  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(b20.mem_ready), 128'd0);
    check("rst_data", b20.data_from_mem, 128'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    req20(1'b0, 1'b1, 32'h0000_0040, PAT);
    check("wr_latency", 128'(last_pulse20 - accept20), 128'd20);
    check("wr_keeps_data", b20.data_from_mem, 128'd0);

    req20(1'b1, 1'b0, 32'h0000_0040, 128'd0);
    check("rd_latency", 128'(last_pulse20 - accept20), 128'd20);
    check("rd_line", b20.data_from_mem, 128'h0123456789ABCDEF0123456789ABCDEF);

    req20(1'b0, 1'b1, 32'h0000_0010, LA);
    req20(1'b0, 1'b1, 32'h0000_4010, LB);
    req20(1'b1, 1'b0, 32'h0000_0010, 128'd0);
    check("alias_rd", b20.data_from_mem, 128'h5A5A5A5A_12345678_9ABCDEF0_5A5A5A5A);
    req20(1'b1, 1'b0, 32'h0000_001C, 128'd0);
    check("offset_rd", b20.data_from_mem, 128'h5A5A5A5A_12345678_9ABCDEF0_5A5A5A5A);

    req20(1'b1, 1'b1, 32'h0000_0080, ONES);
    check("rdwr_no_data", b20.data_from_mem, 128'h5A5A5A5A_12345678_9ABCDEF0_5A5A5A5A);
    req20(1'b1, 1'b0, 32'h0000_0080, 128'd0);
    check("rdwr_wrote", b20.data_from_mem, {128{1'b1}});

    // Abort a write ten cycles into its busy period
    req20(1'b0, 1'b1, 32'h0000_0200, OLD);
    b20.mem_write   = 1'b1;
    b20.mem_addr    = 32'h0000_0200;
    b20.data_to_mem = NEW;
    repeat (11) @(posedge clk);
    #1;
    reset   = 1'b0;
    pulse20 = -1;
    exp_d20 = '0;
    #1;
    check("abort_ready", 128'(b20.mem_ready), 128'd0);
    check("abort_data", b20.data_from_mem, 128'd0);
    repeat (3) @(posedge clk);
    #2;
    b20.mem_write = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    req20(1'b1, 1'b0, 32'h0000_0200, 128'd0);
    check("abort_kept_old", b20.data_from_mem, 128'h00001111_22223333_44445555_66667777);

    // LATENCY=1: two held writes, then four held reads
    b1.mem_write   = 1'b1;
    b1.mem_addr    = 32'h0000_0030;
    b1.data_to_mem = D1;
    p1_start       = cyc + 2;
    repeat (6) @(posedge clk);
    #1;
    b1.mem_write = 1'b0;
    b1.mem_read  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    b1.mem_read = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("l1_data_held", b1.data_from_mem, 128'hC0FFEE00_11223344_55667788_99AABBCC);

`ifdef MEM_STATS_EN
    check("rd_count1", 128'(rc1), 128'd4);
    check("wr_count1", 128'(wc1), 128'd2);
    check("rd_count20", 128'(rc20), 128'd1);
    check("wr_count20", 128'(wc20), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
